// File: rtl/cacheline_adaptor_pkg.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor_pkg
//   Shared types and constants for the cache <-> burst-memory adaptor.
//   cacheline_t      : one full cache line (256 bits)
//   burst_t          : one memory beat (64 bits)
//   adaptor_state_t  : adaptor controller states
//   BEATS            : beats per line for the default geometry
// ---------------------------------------------------------------------------
package cacheline_adaptor_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef logic [255:0] cacheline_t;
  typedef logic [63:0]  burst_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor
//   Bridges the L1 cache's full-line port to a burst-oriented main memory.
//   A writeback line is serialized into BEATS beats; a fill assembles BEATS
//   beats into one line. Only one transaction is in flight at a time.
//
//   Ports
//     clk, rst_n   : clock, asynchronous active-low reset
//     line_i       : writeback line from the cache
//     line_o       : assembled fill line to the cache
//     address_i    : cache-side line address
//     read_i       : cache fill request (held until resp_o)
//     write_i      : cache writeback request (held until resp_o)
//     resp_o       : one-cycle completion pulse to the cache
//     burst_i      : memory read beat
//     burst_o      : memory write beat
//     address_o    : line-aligned burst address
//     read_o       : memory burst read request
//     write_o      : memory burst write request
//     resp_i       : memory beat strobe (one beat per high cycle)
// ---------------------------------------------------------------------------
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_W,
  parameter int BURST_WIDTH = BURST_W,
  parameter int ADDR_WIDTH  = ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEAT_N = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = $clog2(BEAT_N);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_N - 1);
  // Clears the byte-offset-within-line bits of the request address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  adaptor_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  // Line buffer viewed as an array of beats; beat 0 is the LS slice.
  logic [BURST_WIDTH-1:0]  beat_slice [BEAT_N];

  genvar gi;
  generate
    for (gi = 0; gi < BEAT_N; gi++) begin : g_slice
      assign beat_slice[gi] = line_q[gi*BURST_WIDTH +: BURST_WIDTH];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;

    case (state_q)
      IDLE: begin
        // Writeback wins when the cache raises both requests.
        if (write_i) begin
          line_d  = line_i;
          addr_d  = address_i & ALIGN_MASK;
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = address_i & ALIGN_MASK;
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end

      RD_BURST: begin
        if (resp_i) begin
          for (int i = 0; i < BEAT_N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              line_d[i*BURST_WIDTH +: BURST_WIDTH] = burst_i;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end

      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // The cache drops its request on resp_o, so always return to IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Moore outputs, decoded from registered state so reset clears them at once
  // -------------------------------------------------------------------------
  assign read_o    = (state_q == RD_BURST);
  assign write_o   = (state_q == WR_BURST);
  assign resp_o    = (state_q == DONE);
  assign line_o    = line_q;
  assign address_o = addr_q;
  assign burst_o   = (state_q == WR_BURST) ? beat_slice[cnt_q] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor
//   Randomized and directed stimulus for cacheline_adaptor. A driver plays
//   both the cache and the memory; each request pushes its expected outcome
//   (aligned address, line, beat count, active cycles) into a queue that a
//   negedge monitor pops when the adaptor signals completion.
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_write;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [7:0]   ncyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_beat = 0;
  int   mon_act = 0;
  int   txn_no = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  exp_t         cur;
  logic [255:0] cur_line;

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        cur      = exp_q[0];
        cur_line = cur.line;
        if (read_o || write_o) begin
          mon_act++;
          chk("address_o", {224'd0, address_o}, {224'd0, cur.addr});
          chk("burst_kind", {254'd0, write_o, read_o}, cur.is_write ? 256'd2 : 256'd1);
        end
        if (write_o) begin
          chk("burst_o", {192'd0, burst_o}, {192'd0, cur_line[mon_beat*64 +: 64]});
        end
        if ((read_o || write_o) && resp_i) mon_beat++;
        if (resp_o) begin
          chk("beat_count", mon_beat, 4);
          chk("burst_cycles", mon_act, {248'd0, cur.ncyc});
          chk("req_low_in_done", {254'd0, read_o, write_o}, 0);
          if (!cur.is_write) chk("line_o", line_o, cur.line);
          $display("txn %0d: %s addr=%h cycles=%0d line=%h", txn_no,
                   cur.is_write ? "WRITE" : "READ ", cur.addr, mon_act, line_o);
          txn_no++;
          void'(exp_q.pop_front());
          mon_beat = 0;
          mon_act  = 0;
        end
      end else if (resp_o || read_o || write_o) begin
        chk("spurious_activity", {253'd0, resp_o, read_o, write_o}, 0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver: one cache request plus the memory side of its burst.
  //   mode 0: random gaps, 1: no gaps, 2: strobe pattern 1,0,1,1,0,1
  //   abort_after >= 0: assert reset after that many beats
  // -------------------------------------------------------------------------
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rdata,
                         input int mode, input int abort_after);
    bit          pat[$];
    int          nstrobe;
    int          k;
    logic [5:0]  fixed_pat;
    exp_t        e;
    fixed_pat = 6'b101101;
    nstrobe = 0;
    while (nstrobe < 4) begin
      bit b;
      if (mode == 1)      b = 1'b1;
      else if (mode == 2) b = fixed_pat[5 - pat.size()];
      else                b = ($urandom_range(2) != 0);
      pat.push_back(b);
      if (b) nstrobe++;
    end
    e.is_write = wr;
    e.addr     = addr & ~32'h1F;
    e.line     = wr ? wline : rdata;
    e.ncyc     = 8'(pat.size());
    exp_q.push_back(e);

    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = wline;
    @(posedge clk); #1;
    chk("accept", {255'd0, wr ? write_o : read_o}, 1);
    // Inputs are don't-care outside IDLE; scramble them.
    address_i = $urandom;
    line_i    = rand_line();

    k = 0;
    foreach (pat[i]) begin
      resp_i  = pat[i];
      burst_i = pat[i] ? rdata[k*64 +: 64] : {$urandom, $urandom};
      @(posedge clk); #1;
      if (pat[i]) k++;
      if (abort_after >= 0 && k == abort_after) begin
        resp_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_write_o", {255'd0, write_o}, 0);
        chk("rst_read_o", {255'd0, read_o}, 0);
        chk("rst_resp_o", {255'd0, resp_o}, 0);
        chk("rst_address_o", {224'd0, address_o}, 0);
        chk("rst_burst_o", {192'd0, burst_o}, 0);
        exp_q.delete();
        mon_beat = 0;
        mon_act  = 0;
        read_i   = 1'b0;
        write_i  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    resp_i = 1'b0;
    chk("done_pulse", {255'd0, resp_o}, 1);
    read_i  = 1'b0;
    write_i = 1'b0;
    @(posedge clk); #1;
    chk("pulse_one_cycle", {255'd0, resp_o}, 0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [255:0] l;
    logic [255:0] d;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_read_o", {255'd0, read_o}, 0);
    chk("reset_write_o", {255'd0, write_o}, 0);
    chk("reset_resp_o", {255'd0, resp_o}, 0);
    chk("reset_line_o", line_o, 0);
    chk("reset_burst_o", {192'd0, burst_o}, 0);
    chk("reset_address_o", {224'd0, address_o}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed fill, no gaps.
    d = {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h1111111111111111};
    run_txn(1'b0, 1'b1, 32'h0000_1234, '0, d, 1, -1);

    // Directed writeback with gaps; beat k is the nibble k+1 repeated.
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = {16{4'(k + 1)}};
    run_txn(1'b1, 1'b0, 32'h8000_0040, l, '0, 2, -1);

    // Both requests high: write must win.
    run_txn(1'b1, 1'b1, $urandom, rand_line(), rand_line(), 0, -1);

    // Stray strobes while idle, then a fill.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    run_txn(1'b0, 1'b1, $urandom, '0, rand_line(), 0, -1);

    // Back-to-back writeback then fill.
    run_txn(1'b1, 1'b0, $urandom, rand_line(), '0, 0, -1);
    run_txn(1'b0, 1'b1, $urandom, '0, rand_line(), 0, -1);

    // Reset mid writeback, then a normal fill.
    run_txn(1'b1, 1'b0, $urandom, rand_line(), '0, 1, 2);
    chk("post_reset_idle", {254'd0, read_o, write_o}, 0);
    run_txn(1'b0, 1'b1, $urandom, '0, rand_line(), 1, -1);

    // Random mix.
    for (int n = 0; n < 20; n++) begin
      bit w;
      w = $urandom_range(1);
      run_txn(w, w ? 1'($urandom_range(1)) : 1'b1, $urandom,
              rand_line(), rand_line(), 0, -1);
    end

    @(posedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
